// File: rtl/axi_llc_pkg.sv
// Shared types and constants for the LLC R-channel merge.
package axi_llc_pkg;

  // Merge FSM: either free to arbitrate or locked to one producer's burst.
  typedef enum logic [0:0] {
    RMergeIdle   = 1'b0,
    RMergeLocked = 1'b1
  } r_merge_state_e;

  // Producer index assignment on the merge inputs.
  localparam int unsigned RMergeReadUnit = 32'd0;
  localparam int unsigned RMergeBypass   = 32'd1;
  localparam int unsigned RMergeNumInp   = 32'd2;

  // Default slave-port R channel beat.
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } axi_llc_r_chan_t;

  // Index following idx, wrapping modulo n.
  function automatic int unsigned r_merge_next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1) % n;
  endfunction

endpackage

// File: rtl/axi_llc_r_skid.sv
// Two-entry skid buffer. Input ready depends only on the registered fill
// count, so there is no combinational path from out_ready_i to in_ready_o.
module axi_llc_r_skid #(
  parameter type dtype = logic
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  dtype       in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output dtype       out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [1:0] count_o
);

  dtype       r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign in_ready_o  = (r_count != 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;
  assign out_data_o  = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign count_o     = r_count;

  // Storage, pointers and fill count; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_llc_r_merge.sv
// Merges R bursts from NumInp producers onto one R channel. Bursts are
// atomic: the winner stays granted until it delivers its last beat.
module axi_llc_r_merge
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumInp   = 32'd2,
  parameter bit          RoundRob = 1'b1,
  parameter type         r_chan_t = axi_llc_r_chan_t,
  localparam int unsigned IdxW    = (NumInp > 32'd1) ? $clog2(NumInp) : 32'd1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  r_chan_t [NumInp-1:0]   inp_r_i,
  input  logic    [NumInp-1:0]   inp_valid_i,
  output logic    [NumInp-1:0]   inp_ready_o,
  output r_chan_t                r_chan_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic                   busy_o,
  output logic    [IdxW-1:0]     sel_o
);

  r_merge_state_e  r_state;
  r_merge_state_e  w_state_nxt;
  logic [IdxW-1:0] r_sel;
  logic [IdxW-1:0] w_sel_nxt;
  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] w_rr_nxt;
  logic [IdxW-1:0] w_cand;
  logic [IdxW-1:0] w_win;
  logic [IdxW-1:0] w_gnt_idx;
  logic            w_found;
  logic            w_gnt;
  logic            w_hs;
  logic            w_space;
  logic [1:0]      w_count;
  r_chan_t         w_beat;

  // Arbiter: first valid producer at or after rr_ptr, or lowest valid index.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < int'(NumInp); k++) begin
      if (RoundRob) begin
        w_cand = IdxW'((32'(r_rr_ptr) + 32'(k)) % NumInp);
      end else begin
        w_cand = IdxW'(k);
      end
      if (!w_found && inp_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grant, handshake and next-state logic; no grant while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr_ptr;
    w_gnt_idx   = '0;
    w_gnt       = 1'b0;
    inp_ready_o = '0;
    case (r_state)
      RMergeIdle: begin
        w_gnt_idx = w_win;
        w_gnt     = w_found & w_space & ~rst_i;
      end
      RMergeLocked: begin
        w_gnt_idx = r_sel;
        w_gnt     = w_space & ~rst_i;
      end
      default: begin
        w_gnt_idx = '0;
        w_gnt     = 1'b0;
      end
    endcase
    if (w_gnt) begin
      inp_ready_o[w_gnt_idx] = 1'b1;
    end else begin
      inp_ready_o = '0;
    end
    w_hs   = w_gnt & inp_valid_i[w_gnt_idx];
    w_beat = inp_r_i[w_gnt_idx];
    if (w_hs) begin
      if (w_beat.last) begin
        w_state_nxt = RMergeIdle;
        w_rr_nxt    = IdxW'(r_merge_next_idx(32'(w_gnt_idx), NumInp));
      end else begin
        w_state_nxt = RMergeLocked;
        w_sel_nxt   = w_gnt_idx;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, locked producer and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= RMergeIdle;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  axi_llc_r_skid #(
    .dtype (r_chan_t)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (w_beat),
    .in_valid_i  (w_hs),
    .in_ready_o  (w_space),
    .out_data_o  (r_chan_o),
    .out_valid_o (r_valid_o),
    .out_ready_i (r_ready_i),
    .count_o     (w_count)
  );

  assign busy_o = (r_state == RMergeLocked) | (w_count != 2'd0);
  assign sel_o  = r_sel;

endmodule

// File: tb/tb_axi_llc_r_merge.sv
// Directed self-checking bench for axi_llc_r_merge (round-robin instance
// plus a fixed-priority instance sharing the same producer stimulus).
module tb_axi_llc_r_merge;
  import axi_llc_pkg::*;

  typedef axi_llc_r_chan_t beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  beat_t [1:0] inp_r;
  logic  [1:0] inp_valid;
  logic  [1:0] inp_ready;
  logic  [1:0] fp_ready;
  beat_t       r_chan;
  beat_t       fp_chan;
  logic        r_valid;
  logic        fp_valid;
  logic        r_ready;
  logic        busy;
  logic        fp_busy;
  logic  [0:0] sel;
  logic  [0:0] fp_sel;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_hs_cyc = -1;
  int    hs_cnt [2];
  logic  [1:0] en;
  beat_t q0 [$];
  beat_t q1 [$];
  beat_t out_q [$];
  int    out_cyc [$];

  axi_llc_r_merge #(.NumInp(2), .RoundRob(1'b1), .r_chan_t(beat_t)) dut (
    .clk_i(clk), .rst_i(rst), .inp_r_i(inp_r), .inp_valid_i(inp_valid),
    .inp_ready_o(inp_ready), .r_chan_o(r_chan), .r_valid_o(r_valid),
    .r_ready_i(r_ready), .busy_o(busy), .sel_o(sel)
  );

  axi_llc_r_merge #(.NumInp(2), .RoundRob(1'b0), .r_chan_t(beat_t)) dut_fp (
    .clk_i(clk), .rst_i(rst), .inp_r_i(inp_r), .inp_valid_i(inp_valid),
    .inp_ready_o(fp_ready), .r_chan_o(fp_chan), .r_valid_o(fp_valid),
    .r_ready_i(r_ready), .busy_o(fp_busy), .sel_o(fp_sel)
  );

  function automatic beat_t mk(input int p, input int s, input bit l);
    beat_t b;
    b      = '0;
    b.id   = 4'(p);
    b.data = 32'hA000_0000 | (32'(p) << 8) | 32'(s);
    b.resp = 2'(p);
    b.last = l;
    return b;
  endfunction

  task automatic drive();
    inp_valid[0] = en[0] && (q0.size() > 0);
    inp_valid[1] = en[1] && (q1.size() > 0);
    inp_r[0]     = (q0.size() > 0) ? q0[0] : '0;
    inp_r[1]     = (q1.size() > 0) ? q1[0] : '0;
  endtask

  // One clock: observe handshakes at negedge, advance producers after posedge.
  task automatic step();
    logic [1:0] hs;
    @(negedge clk);
    hs = inp_valid & inp_ready;
    if (hs != 2'b00 && first_hs_cyc < 0) first_hs_cyc = cyc;
    if (hs[0]) hs_cnt[0]++;
    if (hs[1]) hs_cnt[1]++;
    if (r_valid && r_ready) begin
      out_q.push_back(r_chan);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 2'b00;
    q0.delete(); q1.delete(); out_q.delete(); out_cyc.delete();
    drive();
    step();
    step();
    rst = 1'b0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    first_hs_cyc = -1;
    out_q.delete(); out_cyc.delete();
    cyc = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (out_q.size() < n && b < budget) begin
      step();
      b++;
    end
    checks++;
    if (out_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats expected %0d", name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; r_ready = 1'b0; en = 2'b00;
    drive();
    step();
    step();
    q0.push_back(mk(0, 0, 1'b1));
    en = 2'b01;
    drive();
    #1;
    checks++; if (r_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid got %b expected 0", r_valid); end
    checks++; if (inp_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b expected 00", inp_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL rst_sel got %b expected 0", sel); end
    checks++; if (r_chan !== beat_t'('0)) begin errors++; $display("FAIL rst_chan got %h expected 0", r_chan); end
    checks++; if ({fp_valid, fp_busy, fp_sel, fp_ready} !== 5'b0) begin
      errors++; $display("FAIL rst_fp got %b expected 00000", {fp_valid, fp_busy, fp_sel, fp_ready});
    end
    checks++; if (fp_chan !== beat_t'('0)) begin errors++; $display("FAIL rst_fp_chan got %h expected 0", fp_chan); end
    rst = 1'b0; en = 2'b00; q0.delete();
    drive();
  endtask

  task automatic test_single_burst();
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, i == 3));
    en = 2'b01;
    drive();
    run_until(4, 30, "single");
    repeat (3) step();
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL single_count got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== mk(0, i, i == 3)) begin
        errors++; $display("FAIL single_beat%0d got %h expected %h", i, out_q[i], mk(0, i, i == 3));
      end
      checks++;
      if (out_cyc[i] != first_hs_cyc + 1 + i) begin
        errors++; $display("FAIL single_cycle%0d got %0d expected %0d", i, out_cyc[i], first_hs_cyc + 1 + i);
      end
    end
  endtask

  task automatic test_both_valid();
    beat_t exp_b;
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, i == 3));
    for (int i = 0; i < 2; i++) q1.push_back(mk(1, i, i == 1));
    en = 2'b11;
    drive();
    run_until(6, 40, "both");
    repeat (3) step();
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL both_count got %0d expected 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      exp_b = (i < 4) ? mk(0, i, i == 3) : mk(1, i - 4, i == 5);
      checks++;
      if (out_q[i] !== exp_b) begin errors++; $display("FAIL both_beat%0d got %h expected %h", i, out_q[i], exp_b); end
    end
    // rr_ptr must have wrapped back to 0: a fresh tie goes to producer 0.
    out_q.delete();
    q0.push_back(mk(0, 8, 1'b1));
    q1.push_back(mk(1, 8, 1'b1));
    drive();
    #1;
    checks++; if (inp_ready !== 2'b01) begin errors++; $display("FAIL both_rrptr got %b expected 01", inp_ready); end
    run_until(2, 10, "both_tie");
    checks++;
    if (out_q.size() < 2 || out_q[0] !== mk(0, 8, 1'b1) || out_q[1] !== mk(1, 8, 1'b1)) begin
      errors++; $display("FAIL both_tie_order got %0d beats first %h", out_q.size(), (out_q.size() > 0) ? out_q[0] : '0);
    end
  endtask

  task automatic test_fairness();
    int b;
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, i, 1'b1));
      q1.push_back(mk(1, i, 1'b1));
    end
    en = 2'b11;
    drive();
    b = 0;
    while (out_q.size() < 8 && b < 40) begin
      #1;
      if (inp_valid == 2'b11) begin
        checks++;
        if (fp_ready !== 2'b01) begin errors++; $display("FAIL fair_fixed_prio got %b expected 01", fp_ready); end
      end
      step();
      b++;
    end
    checks++; if (out_q.size() < 8) begin errors++; $display("FAIL fair_timeout got %0d beats expected 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== mk(i % 2, i / 2, 1'b1)) begin
        errors++; $display("FAIL fair_beat%0d got %h expected %h", i, out_q[i], mk(i % 2, i / 2, 1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, i == 3));
    en = 2'b01;
    drive();
    step();
    step();
    r_ready = 1'b0;
    repeat (5) step();
    #1;
    checks++; if (inp_ready !== 2'b00) begin errors++; $display("FAIL bp_ready got %b expected 00", inp_ready); end
    checks++; if (r_valid !== 1'b1)    begin errors++; $display("FAIL bp_valid got %b expected 1", r_valid); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL bp_busy got %b expected 1", busy); end
    checks++; if (out_q.size() != 1)   begin errors++; $display("FAIL bp_drained got %0d expected 1", out_q.size()); end
    r_ready = 1'b1;
    run_until(4, 30, "bp");
    repeat (3) step();
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d expected 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== mk(0, i, i == 3)) begin
        errors++; $display("FAIL bp_beat%0d got %h expected %h", i, out_q[i], mk(0, i, i == 3));
      end
    end
  endtask

  task automatic test_locked_stall();
    int b;
    beat_t exp_b;
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, i == 3));
    q1.push_back(mk(1, 0, 1'b1));
    en = 2'b11;
    drive();
    b = 0;
    while (hs_cnt[0] < 2 && b < 20) begin
      step();
      b++;
    end
    en[0] = 1'b0;
    drive();
    repeat (4) begin
      #1;
      checks++; if (inp_ready[1] !== 1'b0) begin errors++; $display("FAIL stall_ready1 got %b expected 0", inp_ready[1]); end
      checks++; if (sel !== 1'b0)          begin errors++; $display("FAIL stall_sel got %b expected 0", sel); end
      step();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b expected 1", busy); end
    en[0] = 1'b1;
    drive();
    run_until(5, 30, "stall");
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      exp_b = (i < 4) ? mk(0, i, i == 3) : mk(1, 0, 1'b1);
      checks++;
      if (out_q[i] !== exp_b) begin errors++; $display("FAIL stall_beat%0d got %h expected %h", i, out_q[i], exp_b); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int b;
    do_reset();
    r_ready = 1'b1;
    q1.push_back(mk(1, 0, 1'b1));
    en = 2'b10;
    drive();
    run_until(1, 10, "rmb_pre");
    step();
    step();
    for (int i = 0; i < 4; i++) q0.push_back(mk(0, i, i == 3));
    en = 2'b01;
    drive();
    b = 0;
    while (hs_cnt[0] < 1 && b < 10) begin
      step();
      b++;
    end
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmb_busy_before got %b expected 1", busy); end
    rst = 1'b1;
    step();
    #1;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rmb_valid got %b expected 0", r_valid); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rmb_busy got %b expected 0", busy); end
    rst = 1'b0;
    q0.delete(); q1.delete(); out_q.delete();
    q0.push_back(mk(0, 9, 1'b1));
    q1.push_back(mk(1, 9, 1'b1));
    en = 2'b11;
    drive();
    #1;
    checks++; if (inp_ready !== 2'b01) begin errors++; $display("FAIL rmb_grant got %b expected 01", inp_ready); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_both_valid();
    test_fairness();
    test_backpressure();
    test_locked_stall();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
